qerv_bufreg2_mw: RTL and testbench

Parametrised next-generation buffer register for the qerv bit-serial/multi-bit datapath.
Holds the 32-bit data word for loads, stores and shifts. Drives store byte-selects and performs load sign/zero extension in-block. Replaces the ad-hoc shift decrement logic with an explicit shift-count FSM that handles amounts not divisible by the datapath width.
Sits between decode/state, the ALU operand-B path and the memory interface.

---
 rtl/qerv_bufreg2_mw.sv | 169 ++++++++++++++++
 tb/tb_qerv_bufreg2_mw.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qerv_bufreg2_mw.sv
// Buffer register for the qerv multi-bit datapath: operand B, store data, load extension, shift count.
// Define QERV_BUFREG2_MISALIGN_EN to add the o_misalign output and suppress misaligned byte selects.
module qerv_bufreg2_mw #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int LB = (BITS_PER_CYCLE > 1) ? $clog2(BITS_PER_CYCLE) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_init,
    input  logic                      i_cnt_done,
    input  logic [1:0]                i_lsb,
    input  logic [1:0]                i_size,
    input  logic                      i_signed,
    input  logic                      i_byte_valid,
    input  logic                      i_op_b_sel,
    input  logic                      i_shift_op,
    input  logic                      i_right_shift_op,
    input  logic [BITS_PER_CYCLE-1:0] i_rs2,
    input  logic [BITS_PER_CYCLE-1:0] i_imm,
    input  logic                      i_load,
    input  logic [31:0]               i_dat,
    output logic [BITS_PER_CYCLE-1:0] o_op_b,
    output logic [BITS_PER_CYCLE-1:0] o_q,
    output logic                      o_sh_done,
    output logic                      o_sh_done_r,
    output logic [LB-1:0]             o_rem,
    output logic [31:0]               o_dat,
    output logic [3:0]                o_sel
`ifdef QERV_BUFREG2_MISALIGN_EN
    ,
    output logic                      o_misalign
`endif
);

    localparam int W = BITS_PER_CYCLE;

    typedef enum logic [1:0] {
        SH_IDLE,
        SH_ALIGN,
        SH_COUNT,
        SH_DONE
    } sh_state_e;

    sh_state_e   state_q, state_d;
    logic [31:0] dat_q, dat_d;
    logic [5:0]  ext_pos_q, ext_pos_d;
    logic        sign_q, sign_d;

    logic [5:0]  next_shamt;
    logic [31:0] shift_in;
    logic [5:0]  cnt_next;
    logic        sh_exec;
    logic        align_req;
    logic [5:0]  width;
    logic [4:0]  width_m1;
    logic [4:0]  sign_idx;
    logic [5:0]  ext_sum;
    logic [5:0]  pos;
    logic [4:0]  idx;
    logic        is_byte;
    logic        is_half;
    logic [3:0]  sel;

    assign o_op_b     = i_op_b_sel ? i_rs2 : i_imm;
    assign next_shamt = {dat_q[5+W] & ~(i_shift_op & i_cnt_done), dat_q[4+W:W]};
    assign shift_in   = {o_op_b, dat_q[31:6+W], next_shamt};
    assign cnt_next   = dat_q[5:0] - 6'(W);
    assign sh_exec    = i_shift_op & ~i_init;
    // A single-bit datapath never has a sub-word remainder to align.
    assign align_req  = (W > 1) ? (|dat_q[LB-1:0]) : 1'b0;

    always_comb begin
        state_d = state_q;
        if (!i_shift_op || i_load) begin
            state_d = SH_IDLE;
        end else if (!i_init) begin
            unique case (state_q)
                SH_IDLE:  state_d = (i_right_shift_op && align_req) ? SH_ALIGN : SH_COUNT;
                SH_ALIGN: state_d = SH_COUNT;
                SH_COUNT: state_d = cnt_next[5] ? SH_DONE : SH_COUNT;
                default:  state_d = SH_DONE;
            endcase
        end
    end

    always_comb begin
        dat_d = dat_q;
        if (i_load) begin
            dat_d = i_dat;
        end else if (sh_exec) begin
            if (state_q == SH_COUNT) dat_d[5:0] = cnt_next;
        end else if (i_shift_op || (i_en && i_byte_valid)) begin
            dat_d = shift_in;
        end
    end

    always_comb begin
        unique case (i_size)
            2'b00:   begin width = 6'd8;  width_m1 = 5'd7;  end
            2'b01:   begin width = 6'd16; width_m1 = 5'd15; end
            default: begin width = 6'd32; width_m1 = 5'd31; end
        endcase
    end

    assign sign_idx = {i_lsb, 3'b000} + width_m1;
    assign ext_sum  = ext_pos_q + 6'(W);

    always_comb begin
        ext_pos_d = ext_pos_q;
        sign_d    = sign_q;
        if (i_load) begin
            ext_pos_d = '0;
            sign_d    = i_signed & i_dat[sign_idx];
        end else if (i_en && !i_init) begin
            ext_pos_d = (ext_sum > 6'd32) ? 6'd32 : ext_sum;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= SH_IDLE;
            dat_q     <= '0;
            ext_pos_q <= '0;
            sign_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dat_q     <= dat_d;
            ext_pos_q <= ext_pos_d;
            sign_q    <= sign_d;
        end
    end

    // Bits past the accessed width are replaced by the captured sign.
    always_comb begin
        o_q = '0;
        pos = '0;
        idx = '0;
        for (int k = 0; k < W; k++) begin
            pos    = ext_pos_q + 6'(k);
            idx    = {i_lsb, 3'b000} + pos[4:0];
            o_q[k] = (pos < width) ? dat_q[idx] : sign_q;
        end
    end

    assign o_sh_done   = sh_exec & (state_q == SH_COUNT) & cnt_next[5];
    assign o_sh_done_r = dat_q[5];
    assign o_rem       = dat_q[LB-1:0];
    assign o_dat       = dat_q;

    assign is_byte = (i_size == 2'b00);
    assign is_half = (i_size == 2'b01);

    always_comb begin
        unique case (1'b1)
            is_byte: sel = 4'b0001 << i_lsb;
            is_half: sel = 4'b0011 << {i_lsb[1], 1'b0};
            default: sel = 4'b1111;
        endcase
    end

`ifdef QERV_BUFREG2_MISALIGN_EN
    assign o_misalign = (is_half & i_lsb[0]) | (~is_byte & ~is_half & (i_lsb != 2'b00));
    assign o_sel      = o_misalign ? 4'b0000 : sel;
`else
    assign o_sel = sel;
`endif

endmodule

// File: tb/tb_qerv_bufreg2_mw.sv
// Directed testbench for qerv_bufreg2_mw, W=4 and W=1 instances.
module tb_qerv_bufreg2_mw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, init, cnt_done, sgn, byte_valid;
    logic        op_b_sel, shift_op, right_shift, load;
    logic [1:0]  lsb, size;
    logic [3:0]  rs2_4, imm_4;
    logic [0:0]  rs2_1, imm_1;
    logic [31:0] dat;

    logic [3:0]  opb4, q4;
    logic [1:0]  rem4;
    logic        shd4, shdr4;
    logic [31:0] dat4;
    logic [3:0]  sel4;
    logic [0:0]  opb1, q1, rem1;
    logic        shd1, shdr1;
    logic [31:0] dat1;
    logic [3:0]  sel1;
`ifdef QERV_BUFREG2_MISALIGN_EN
    logic        mis4, mis1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] acc;

    assign rs2_1 = rs2_4[0];
    assign imm_1 = imm_4[0];

    always #5 clk = ~clk;

    qerv_bufreg2_mw #(.BITS_PER_CYCLE(4)) u_w4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init),
        .i_cnt_done(cnt_done), .i_lsb(lsb), .i_size(size), .i_signed(sgn),
        .i_byte_valid(byte_valid), .i_op_b_sel(op_b_sel), .i_shift_op(shift_op),
        .i_right_shift_op(right_shift), .i_rs2(rs2_4), .i_imm(imm_4),
        .i_load(load), .i_dat(dat), .o_op_b(opb4), .o_q(q4),
        .o_sh_done(shd4), .o_sh_done_r(shdr4), .o_rem(rem4),
        .o_dat(dat4), .o_sel(sel4)
`ifdef QERV_BUFREG2_MISALIGN_EN
        , .o_misalign(mis4)
`endif
    );

    qerv_bufreg2_mw #(.BITS_PER_CYCLE(1)) u_w1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init),
        .i_cnt_done(cnt_done), .i_lsb(lsb), .i_size(size), .i_signed(sgn),
        .i_byte_valid(byte_valid), .i_op_b_sel(op_b_sel), .i_shift_op(shift_op),
        .i_right_shift_op(right_shift), .i_rs2(rs2_1), .i_imm(imm_1),
        .i_load(load), .i_dat(dat), .o_op_b(opb1), .o_q(q1),
        .o_sh_done(shd1), .o_sh_done_r(shdr1), .o_rem(rem1),
        .o_dat(dat1), .o_sel(sel1)
`ifdef QERV_BUFREG2_MISALIGN_EN
        , .o_misalign(mis1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Init phase: shift an operand in through the immediate, LSB nibble first.
    task automatic shift_init(input logic [31:0] val);
        op_b_sel = 1'b0;
        shift_op = 1'b1;
        init     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imm_4    = val[4*i +: 4];
            cnt_done = (i == 7);
            tick();
        end
        init     = 1'b0;
        cnt_done = 1'b0;
        imm_4    = '0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 0; init = 0; cnt_done = 0; sgn = 0;
        byte_valid = 0; op_b_sel = 0; shift_op = 0; right_shift = 0;
        load = 0; lsb = 0; size = 0; rs2_4 = 0; imm_4 = 0; dat = 0;
        #12;
        check("rst_q", 32'(q4), 32'h0);
        check("rst_sh_done", 32'(shd4), 32'h0);
        check("rst_sh_done_r", 32'(shdr4), 32'h0);
        check("rst_rem", 32'(rem4), 32'h0);
        check("rst_dat", dat4, 32'h0);
        rst_n = 1'b1;
        tick();

        op_b_sel = 1'b1; rs2_4 = 4'hA; imm_4 = 4'h5; #1;
        check("opb_rs2", 32'(opb4), 32'hA);
        op_b_sel = 1'b0; #1;
        check("opb_imm", 32'(opb4), 32'h5);

        // SRLI by 6: remainder 2 forces one align cycle
        right_shift = 1'b1;
        shift_init(32'd6);
        check("srli_rem", 32'(rem4), 32'h2);
        check("srli_cnt0", 32'(dat4[5:0]), 32'd6);
        check("srli_idle_done", 32'(shd4), 32'h0);
        tick();
        check("srli_align_cnt", 32'(dat4[5:0]), 32'd6);
        check("srli_align_done", 32'(shd4), 32'h0);
        tick();
        check("srli_cnt1_done", 32'(shd4), 32'h0);
        tick();
        check("srli_cnt2_val", 32'(dat4[5:0]), 32'd2);
        check("srli_cnt2_done", 32'(shd4), 32'h1);
        tick();
        check("srli_wrap", 32'(dat4[5:0]), 32'd62);
        check("srli_done_r", 32'(shdr4), 32'h1);
        check("srli_frozen_done", 32'(shd4), 32'h0);
        shift_op = 1'b0;
        tick();

        // SLLI by 8: no align, done on third count cycle
        right_shift = 1'b0;
        shift_init(32'd8);
        check("slli_rem", 32'(rem4), 32'h0);
        tick();
        check("slli_cnt1_val", 32'(dat4[5:0]), 32'd8);
        check("slli_cnt1_done", 32'(shd4), 32'h0);
        tick();
        check("slli_cnt2_val", 32'(dat4[5:0]), 32'd4);
        check("slli_cnt2_done", 32'(shd4), 32'h0);
        tick();
        check("slli_cnt3_done", 32'(shd4), 32'h1);
        tick();
        check("slli_wrap", 32'(dat4[5:0]), 32'd60);
        check("slli_done_r", 32'(shdr4), 32'h1);
        shift_op = 1'b0;
        tick();

        // Reset in the middle of counting
        shift_init(32'd12);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_q", 32'(q4), 32'h0);
        check("mid_rst_sh_done", 32'(shd4), 32'h0);
        check("mid_rst_sh_done_r", 32'(shdr4), 32'h0);
        check("mid_rst_rem", 32'(rem4), 32'h0);
        check("mid_rst_dat", dat4, 32'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_idle", 32'(shd4), 32'h0);
        tick();
        check("post_rst_cnt", 32'(dat4[5:0]), 32'd0);
        check("post_rst_done", 32'(shd4), 32'h1);
        shift_op = 1'b0;
        tick();

        // Load wins over a simultaneous shift
        shift_op = 1'b1; init = 1'b1; load = 1'b1; dat = 32'hA5A5_0F0F;
        tick();
        check("load_prio", dat4, 32'hA5A5_0F0F);
        load = 1'b0; init = 1'b0;
        #1;
        check("load_prio_idle", 32'(shd4), 32'h0);
        shift_op = 1'b0;
        tick();

        // Store data shift-in via rs2
        op_b_sel = 1'b1; en = 1'b1; byte_valid = 1'b1;
        acc = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            rs2_4 = acc[4*i +: 4];
            tick();
        end
        check("store_data", dat4, 32'h1234_5678);
        en = 1'b0; byte_valid = 1'b0;

        // LH signed, W=1
        size = 2'b01; lsb = 2'b00; sgn = 1'b1; dat = 32'h0000_8000; load = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        check("lh_dat", dat1, 32'h0000_8000);
        for (int i = 0; i < 32; i++) begin
            #1;
            acc[i] = q1[0];
            tick();
        end
        check("lh_signed_w1", acc, 32'hFFFF_8000);
        en = 1'b0;

        // LH unsigned, W=1
        sgn = 1'b0; load = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1;
            acc[i] = q1[0];
            tick();
        end
        check("lh_unsigned_w1", acc, 32'h0000_8000);
        en = 1'b0;

        // LB signed at byte 1, W=4
        size = 2'b00; lsb = 2'b01; sgn = 1'b1; load = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            acc[4*i +: 4] = q4;
            tick();
        end
        check("lb_signed_w4", acc, 32'hFFFF_FF80);
        en = 1'b0; sgn = 1'b0;

        // Store byte selects
        size = 2'b00; lsb = 2'd3; #1;
        check("sel_sb3", 32'(sel4), 32'h8);
        size = 2'b01; lsb = 2'd2; #1;
        check("sel_sh2", 32'(sel4), 32'hC);
        size = 2'b01; lsb = 2'd0; #1;
        check("sel_sh0", 32'(sel4), 32'h3);
        size = 2'b10; lsb = 2'd0; #1;
        check("sel_sw", 32'(sel4), 32'hF);
        size = 2'b11; lsb = 2'd0; #1;
        check("sel_sz11", 32'(sel4), 32'hF);
`ifdef QERV_BUFREG2_MISALIGN_EN
        size = 2'b10; lsb = 2'd1; #1;
        check("mis_sw1", 32'(mis4), 32'h1);
        check("mis_sw1_sel", 32'(sel4), 32'h0);
        size = 2'b01; lsb = 2'd1; #1;
        check("mis_sh1", 32'(mis4), 32'h1);
        size = 2'b00; lsb = 2'd1; #1;
        check("mis_sb1", 32'(mis4), 32'h0);
        check("mis_sb1_sel", 32'(sel4), 32'h2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
